fu_sequencer: RTL
=================

Name: fu_sequencer

Overview:
Multicycle controller that drives the 8-bit function unit from the issuing side. It fetches 16-bit instructions over a valid/req handshake and drives A, B and the {S2,S1,S0,Cin} select onto the function unit. It captures result G into a 4x8 register file and captures status N/Z/C into a flag register. It also executes load-immediate, conditional branch and halt, so the function unit plus this block form a minimal programmable datapath.

Parameters:
START_PC, 8'h00, PC value loaded on reset and on restart from HALT.

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins execution from IDLE or HALT
pc  output  8  instruction address, valid while instr_req=1
instr_req  output  1  high in FETCH state only
instr_valid  input  1  instr is valid this cycle; sampled only in FETCH
instr  input  16  instruction word
fu_a  output  8  function unit operand A
fu_b  output  8  function unit operand B
fu_sel  output  4  {S2,S1,S0,Cin} to function unit
fu_g  input  8  function unit result G
fu_n  input  1  function unit N
fu_z  input  1  function unit Z
fu_c  input  1  function unit C; the V output of the function unit is not connected
flags  output  3  registered {N,Z,C}
busy  output  1  high in FETCH/EXEC
halted  output  1  high in HALT
dbg_sel  input  2  register index for debug read
dbg_data  output  8  combinational read of R[dbg_sel]

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. Encoding is free.
- Reset (rst=1 at an edge, any state): state=IDLE, pc=START_PC, R0..R3=0, flags=0, IR=0. Outputs are then instr_req=0, busy=0, halted=0, fu_a=0, fu_b=0, fu_sel=0. Reset mid-fetch or mid-exec discards the instruction; no register or flag write occurs.
- IDLE: start=1 -> FETCH.
- FETCH: instr_req=1, pc driven. instr_valid=1 -> IR<=instr, go to EXEC. Otherwise stay; pc and registers hold.
- EXEC: lasts exactly 1 cycle. Minimum 2 cycles per instruction.
- Outside EXEC: fu_a=0, fu_b=0, fu_sel=4'b0000.
- start is ignored in FETCH/EXEC. instr_valid is ignored outside FETCH.
- Instruction format, IR[15:12]=op.
- ALU class, op != 4'b1111. Fields: rd=IR[11:10], ra=IR[9:8], rb=IR[7:6]; IR[5:0] ignored.
  - In EXEC, drive fu_a=R[ra], fu_b=R[rb], fu_sel=op.
  - At the EXEC edge: R[rd]<=fu_g, N<=fu_n, Z<=fu_z.
  - C<=fu_c only for op 0001..0110. For op 0000, 0111 and 1000..1110, C holds its previous value.
  - pc<=pc+1.
- Control class, op == 4'b1111. fu_sel stays 4'b0000; 4'b1111 is never driven onto fu_sel.
  - IR[11:10]=00 LDI: R[IR[9:8]]<=IR[7:0]; flags unchanged; pc+1.
  - 01 BR: cond=IR[9:8]: 00 always, 01 Z, 10 N, 11 C, using flags as registered before this EXEC. Taken -> pc<=IR[7:0]; else pc+1. Flags unchanged.
  - 10 HALT: state<=HALT; pc unchanged.
  - 11 NOP: pc+1.
- After a non-HALT EXEC -> FETCH.
- pc arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
- Register file: same-register sources are allowed (ra=rb=rd). Reads in EXEC see pre-write values.
- HALT: halted=1, busy=0, instr_req=0, registers and flags retained. start=1 -> pc<=START_PC, FETCH, halted=0.
- dbg_data is combinational and reflects writes from the cycle after the write edge.

Test Plan:
- Basic add: rst, start; LDI R1,05; LDI R2,03; op 0010 rd=3 ra=1 rb=2 -> during EXEC fu_sel=4'b0010, fu_a=05, fu_b=03. Then R3=08, flags N=0 Z=0 C=0, pc advanced 3.
- Carry retention: LDI R1,FF; op 0001 rd=0 ra=1 -> R0=00, Z=1, C=1. Next op 1000 rd=0 ra=1 rb=1 -> R0=FF, N=1, Z=0, C stays 1.
- Branch: with Z=1, BR cond=01 target 8'h10 -> next pc=10. Repeat with Z=0 from pc=20 -> next pc=21. BR always -> target regardless of flags.
- Fetch stall: instr_valid held low 5 cycles -> instr_req=1, pc stable, no register/flag change. Valid on cycle 6 -> EXEC next cycle.
- Halt/restart/reset: HALT at pc=04 -> halted=1, busy=0, instr_req=0, registers retained. start -> pc=START_PC, FETCH. rst asserted during EXEC of an ADD -> no write, all registers 0, IDLE next cycle.
- Wrap: NOP at pc=FF -> next fetch pc=00.

Source files
------------

// File: rtl/fu_sequencer.sv
// Multicycle issue controller for the 8-bit function unit: fetch, execute,
// 4x8 register file, {N,Z,C} flags, plus load-immediate, branch and halt.
module fu_sequencer #(
  parameter logic [7:0] START_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  pc,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic [7:0]  fu_a,
  output logic [7:0]  fu_b,
  output logic [3:0]  fu_sel,
  input  logic [7:0]  fu_g,
  input  logic        fu_n,
  input  logic        fu_z,
  input  logic        fu_c,
  output logic [2:0]  flags,
  output logic        busy,
  output logic        halted,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_CTRL  = 4'b1111;
  localparam logic [1:0] CT_LDI   = 2'b00;
  localparam logic [1:0] CT_BR    = 2'b01;
  localparam logic [1:0] CT_HALT  = 2'b10;

  state_t          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [2:0]      flags_q, flags_d;

  logic [3:0] op;
  logic [1:0] rd, ra, rb;
  logic [7:0] pc_inc;
  logic       br_taken;
  logic       c_update;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:10];
  assign ra     = ir_q[9:8];
  assign rb     = ir_q[7:6];
  assign pc_inc = pc_q + 8'd1;

  // Branch condition is judged against the flags held before this EXEC.
  always_comb begin
    br_taken = 1'b0;
    unique case (ir_q[9:8])
      2'b00: br_taken = 1'b1;
      2'b01: br_taken = flags_q[1];
      2'b10: br_taken = flags_q[2];
      2'b11: br_taken = flags_q[0];
    endcase
  end

  // Only the arithmetic selects 0001..0110 produce a meaningful carry.
  assign c_update = (op >= 4'b0001) && (op <= 4'b0110);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    fu_a    = 8'h00;
    fu_b    = 8'h00;
    fu_sel  = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (op != OP_CTRL) begin
          fu_a       = regs_q[ra];
          fu_b       = regs_q[rb];
          fu_sel     = op;
          regs_d[rd] = fu_g;
          flags_d[2] = fu_n;
          flags_d[1] = fu_z;
          if (c_update) flags_d[0] = fu_c;
          pc_d       = pc_inc;
        end else begin
          unique case (ir_q[11:10])
            CT_LDI: begin
              regs_d[ir_q[9:8]] = ir_q[7:0];
              pc_d              = pc_inc;
            end
            CT_BR:   pc_d    = br_taken ? ir_q[7:0] : pc_inc;
            CT_HALT: state_d = S_HALT;
            default: pc_d    = pc_inc;
          endcase
        end
      end

      S_HALT: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      ir_q    <= 16'h0000;
      regs_q  <= '0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  assign pc        = pc_q;
  assign instr_req = (state_q == S_FETCH);
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign flags     = flags_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule
